cypher_detector_param: RTL

- Parametrised sequential cypher detector with integrated control FSM.
- Compares a stream of NUM_DIGITS digits, each DIGIT_W bits wide, in order against a stored cypher. Keeps a running digit sum for the current attempt.
- Counts failed attempts and enters a timed lockout after MAX_FAILS consecutive failures.
- Sits between the keypad/input sequencer and the display/unlock logic. Replaces the fixed 4x4-bit datapath plus external controller.

---
 rtl/cypher_detector_param_if.sv | 35 +++
 rtl/cypher_detector_param.sv | 130 +++++++++++++
 2 files changed

// File: rtl/cypher_detector_param_if.sv
// Keypad-side bundle for the cypher detector: cypher load,
// digit handshake and the status outputs.
interface cypher_detector_param_if #(
    parameter int DIGIT_W    = 4,
    parameter int NUM_DIGITS = 4,
    parameter int SUM_W      = 10,
    parameter int MAX_FAILS  = 3
);
    localparam int PW = $clog2(NUM_DIGITS + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);

    logic                          load_cypher;
    logic [DIGIT_W*NUM_DIGITS-1:0] cypher_in;
    logic                          digit_valid;
    logic [DIGIT_W-1:0]            digit_in;
    logic                          digit_ready;
    logic                          match;
    logic                          mismatch;
    logic [PW-1:0]                 progress;
    logic [SUM_W-1:0]              sum;
    logic [FW-1:0]                 fail_count;
    logic                          locked;

    modport master (
        output load_cypher, cypher_in, digit_valid, digit_in,
        input  digit_ready, match, mismatch, progress, sum,
        input  fail_count, locked
    );

    modport slave (
        input  load_cypher, cypher_in, digit_valid, digit_in,
        output digit_ready, match, mismatch, progress, sum,
        output fail_count, locked
    );
endinterface

// File: rtl/cypher_detector_param.sv
// Sequential cypher detector: in-order digit compare, running sum,
// consecutive-failure counting and a timed lockout.
module cypher_detector_param #(
    parameter int DIGIT_W     = 4,
    parameter int NUM_DIGITS  = 4,
    parameter int SUM_W       = 10,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 16
) (
    input logic                     clock,
    input logic                     reset,
    cypher_detector_param_if.slave  bus
);
    localparam int TOT = DIGIT_W * NUM_DIGITS;
    localparam int PW  = $clog2(NUM_DIGITS + 1);
    localparam int FW  = $clog2(MAX_FAILS + 1);
    localparam int TW  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ENTRY, LOCKED} state_e;

    state_e           state_q, state_d;
    logic [TOT-1:0]   cyp_q, cyp_d;
    logic [PW-1:0]    progress_q, progress_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [FW-1:0]    fail_q, fail_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             match_q, match_d;
    logic             mism_q, mism_d;

    logic             ready;
    logic             accept;
    logic             hit;
    logic             last;
    logic             fail_max;
    logic [TOT-1:0]   cyp_shift;
    logic [DIGIT_W-1:0] exp_digit;

    // Digit 0 sits in the MSBs, so shift the wanted digit to the top.
    assign cyp_shift = cyp_q << (DIGIT_W * int'(progress_q));
    assign exp_digit = cyp_shift[TOT-1 -: DIGIT_W];

    assign ready    = (state_q != LOCKED) && !bus.load_cypher;
    assign accept   = bus.digit_valid && ready;
    assign hit      = (bus.digit_in == exp_digit);
    assign last     = (progress_q == PW'(NUM_DIGITS - 1));
    assign fail_max = (fail_q == FW'(MAX_FAILS - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cyp_q      <= '0;
            progress_q <= '0;
            sum_q      <= '0;
            fail_q     <= '0;
            timer_q    <= '0;
            match_q    <= 1'b0;
            mism_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyp_q      <= cyp_d;
            progress_q <= progress_d;
            sum_q      <= sum_d;
            fail_q     <= fail_d;
            timer_q    <= timer_d;
            match_q    <= match_d;
            mism_q     <= mism_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOCKED: begin
                if (timer_q == '0) state_d = IDLE;
            end
            default: begin
                if (bus.load_cypher) begin
                    state_d = IDLE;
                end else if (accept) begin
                    if (!hit)      state_d = fail_max ? LOCKED : IDLE;
                    else if (last) state_d = IDLE;
                    else           state_d = ENTRY;
                end
            end
        endcase
    end

    always_comb begin
        cyp_d      = cyp_q;
        progress_d = progress_q;
        sum_d      = sum_q;
        fail_d     = fail_q;
        timer_d    = timer_q;
        match_d    = 1'b0;
        mism_d     = 1'b0;
        if (state_q == LOCKED) begin
            timer_d = timer_q - 1'b1;
            if (timer_q == '0) fail_d = '0;
        end else if (bus.load_cypher) begin
            cyp_d      = bus.cypher_in;
            progress_d = '0;
            sum_d      = '0;
        end else if (accept) begin
            // A new attempt restarts the sum with its first digit.
            sum_d      = (progress_q == '0) ? SUM_W'(bus.digit_in)
                                            : sum_q + SUM_W'(bus.digit_in);
            progress_d = '0;
            if (!hit) begin
                mism_d  = 1'b1;
                fail_d  = fail_q + 1'b1;
                timer_d = TW'(LOCK_CYCLES - 1);
            end else if (last) begin
                match_d = 1'b1;
                fail_d  = '0;
            end else begin
                progress_d = progress_q + 1'b1;
            end
        end
    end

    always_comb begin
        bus.digit_ready = ready;
        bus.match       = match_q;
        bus.mismatch    = mism_q;
        bus.progress    = progress_q;
        bus.sum         = sum_q;
        bus.fail_count  = fail_q;
        bus.locked      = (state_q == LOCKED);
    end
endmodule
